// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C transfer sequencer: core register map,
// command codes, CMDR status bits and the sequencer's state/status enums.
package i2c_seq_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam logic [7:0] CMD_WAIT     = 8'h00;
    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ_ACK = 8'h02;
    localparam logic [7:0] CMD_READ_NAK = 8'h03;
    localparam logic [7:0] CMD_START    = 8'h04;
    localparam logic [7:0] CMD_STOP     = 8'h05;
    localparam logic [7:0] CMD_SET_BUS  = 8'h06;

    localparam logic [7:0] CSR_ENABLE  = 8'hC0;
    localparam logic [7:0] CSR_DISABLE = 8'h00;

    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    typedef enum logic [2:0] {
        STAT_OK       = 3'd0,
        STAT_NAK      = 3'd1,
        STAT_ARB_LOST = 3'd2,
        STAT_ERR      = 3'd3,
        STAT_TIMEOUT  = 3'd4
    } status_e;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETBUS,
        ST_START,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STOP,
        ST_RESP,
        ST_RECOVER
    } state_e;

    // Sub-steps inside one top state: optional register write, command write,
    // done wait (IRQ and/or CMDR poll), and the read-data fetch.
    typedef enum logic [2:0] {
        SP_REG,
        SP_CMD,
        SP_IRQ,
        SP_POLL,
        SP_RDDPR
    } step_e;

    function automatic logic cmdr_done(input logic [7:0] cmdr);
        return cmdr[CMDR_DON] | cmdr[CMDR_NAK] | cmdr[CMDR_AL] | cmdr[CMDR_ERR];
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Single-beat Wishbone master engine: one registered access per start request,
// held until ack, with a mandatory idle cycle between accesses.
module wb_single_access #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i
);

    assign busy = cyc_o;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
            rdata <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cyc_o) begin
                if (ack_i) begin
                    cyc_o <= 1'b0;
                    stb_o <= 1'b0;
                    we_o  <= 1'b0;
                    rdata <= dat_i;
                    done  <= 1'b1;
                end
            end else if (start && !done) begin
                // The done cycle always has cyc_o low, guaranteeing the idle gap.
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= we;
                adr_o <= adr;
                dat_o <= wdata;
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Turns single-byte I2C read/write requests into the full command sequence for
// the multi-bus I2C master core and reports data plus completion status.
module i2c_xfer_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int USE_IRQ        = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rd_i,
    input  logic [3:0]            req_bus_i,
    input  logic [6:0]            req_addr_i,
    input  logic [7:0]            req_data_i,
    output logic                  rsp_valid_o,
    output logic [7:0]            rsp_data_o,
    output logic [2:0]            rsp_status_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e  state, state_next;
    step_e   step, step_next;
    status_e status_q, status_next;

    logic [15:0] timer;
    logic [3:0]  cur_bus;
    logic        cur_valid;
    logic        req_rd_q;
    logic [3:0]  req_bus_q;
    logic [6:0]  req_addr_q;
    logic [7:0]  req_data_q;
    logic [7:0]  rsp_data_q;
    logic        recover_q;

    logic                  acc_start, acc_we, acc_busy, acc_done;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [DATA_WIDTH-1:0] acc_wdata, acc_rdata;
    logic [7:0]            reg_byte, cmd_byte, cmdr;

    logic capture, timer_clr, bus_update, bus_invalidate, load_rdata;
    logic set_status, set_recover, clr_recover, timeout;

    wb_single_access #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (acc_start),
        .we    (acc_we),
        .adr   (acc_adr),
        .wdata (acc_wdata),
        .busy  (acc_busy),
        .done  (acc_done),
        .rdata (acc_rdata),
        .cyc_o (cyc_o),
        .stb_o (stb_o),
        .we_o  (we_o),
        .adr_o (adr_o),
        .dat_o (dat_o),
        .ack_i (ack_i),
        .dat_i (dat_i)
    );

    assign cmdr    = acc_rdata[7:0];
    assign timeout = (timer >= TMO_LAST);

    always_comb begin
        reg_byte = 8'h00;
        cmd_byte = CMD_WAIT;
        case (state)
            ST_INIT:    reg_byte = CSR_ENABLE;
            ST_RECOVER: reg_byte = CSR_DISABLE;
            ST_SETBUS:  begin reg_byte = {4'h0, req_bus_q};     cmd_byte = CMD_SET_BUS;  end
            ST_START:   cmd_byte = CMD_START;
            ST_ADDR:    begin reg_byte = {req_addr_q, req_rd_q}; cmd_byte = CMD_WRITE;    end
            ST_WDATA:   begin reg_byte = req_data_q;            cmd_byte = CMD_WRITE;    end
            ST_RDATA:   cmd_byte = CMD_READ_NAK;
            ST_STOP:    cmd_byte = CMD_STOP;
            default:    ;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        step_next      = step;
        status_next    = status_q;
        acc_start      = 1'b0;
        acc_we         = 1'b1;
        acc_adr        = ADDR_WIDTH'(REG_CMDR);
        acc_wdata      = DATA_WIDTH'(cmd_byte);
        capture        = 1'b0;
        timer_clr      = 1'b0;
        bus_update     = 1'b0;
        bus_invalidate = 1'b0;
        load_rdata     = 1'b0;
        set_status     = 1'b0;
        set_recover    = 1'b0;
        clr_recover    = 1'b0;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;

        case (step)
            SP_REG: begin
                acc_adr   = (state == ST_INIT || state == ST_RECOVER) ?
                            ADDR_WIDTH'(REG_CSR) : ADDR_WIDTH'(REG_DPR);
                acc_wdata = DATA_WIDTH'(reg_byte);
            end
            SP_POLL:  acc_we = 1'b0;
            SP_RDDPR: begin acc_we = 1'b0; acc_adr = ADDR_WIDTH'(REG_DPR); end
            default:  ;
        endcase

        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    capture     = 1'b1;
                    set_status  = 1'b1;
                    status_next = STAT_OK;
                    if (cur_valid && req_bus_i == cur_bus) begin
                        state_next = ST_START;
                        step_next  = SP_CMD;
                    end else begin
                        state_next = ST_SETBUS;
                        step_next  = SP_REG;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (recover_q) begin
                    clr_recover = 1'b1;
                    state_next  = ST_RECOVER;
                    step_next   = SP_REG;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                case (step)
                    SP_REG: begin
                        acc_start = !acc_busy && !acc_done;
                        if (acc_done) begin
                            if (state == ST_INIT) begin
                                state_next = ST_IDLE;
                            end else if (state == ST_RECOVER) begin
                                state_next = ST_INIT;
                            end else begin
                                step_next = SP_CMD;
                            end
                        end
                    end
                    SP_CMD: begin
                        acc_start = !acc_busy && !acc_done;
                        if (acc_done) begin
                            timer_clr = 1'b1;
                            step_next = (USE_IRQ != 0) ? SP_IRQ : SP_POLL;
                        end
                    end
                    SP_IRQ: begin
                        if (timeout) begin
                            set_status  = 1'b1;
                            status_next = STAT_TIMEOUT;
                            set_recover = 1'b1;
                            state_next  = ST_RESP;
                        end else if (irq_i) begin
                            step_next = SP_POLL;
                        end
                    end
                    SP_POLL: begin
                        if (acc_done) begin
                            if (cmdr[CMDR_ERR]) begin
                                set_status  = 1'b1;
                                status_next = STAT_ERR;
                                state_next  = ST_RESP;
                            end else if (cmdr[CMDR_AL]) begin
                                set_status     = 1'b1;
                                status_next    = STAT_ARB_LOST;
                                bus_invalidate = 1'b1;
                                state_next     = ST_RESP;
                            end else if (cmdr[CMDR_NAK] && (state == ST_ADDR || state == ST_WDATA)) begin
                                set_status  = 1'b1;
                                status_next = STAT_NAK;
                                state_next  = ST_STOP;
                                step_next   = SP_CMD;
                            end else if (cmdr_done(cmdr)) begin
                                case (state)
                                    ST_SETBUS: begin
                                        bus_update = 1'b1;
                                        state_next = ST_START;
                                        step_next  = SP_CMD;
                                    end
                                    ST_START: begin
                                        state_next = ST_ADDR;
                                        step_next  = SP_REG;
                                    end
                                    ST_ADDR: begin
                                        state_next = req_rd_q ? ST_RDATA : ST_WDATA;
                                        step_next  = req_rd_q ? SP_CMD : SP_REG;
                                    end
                                    ST_WDATA: begin
                                        state_next = ST_STOP;
                                        step_next  = SP_CMD;
                                    end
                                    ST_RDATA: step_next  = SP_RDDPR;
                                    default:  state_next = ST_RESP;
                                endcase
                            end else begin
                                step_next = (USE_IRQ != 0) ? SP_IRQ : SP_POLL;
                            end
                        end else if (!acc_busy && timeout) begin
                            set_status  = 1'b1;
                            status_next = STAT_TIMEOUT;
                            set_recover = 1'b1;
                            state_next  = ST_RESP;
                        end else begin
                            acc_start = !acc_busy;
                        end
                    end
                    SP_RDDPR: begin
                        acc_start = !acc_busy && !acc_done;
                        if (acc_done) begin
                            load_rdata = 1'b1;
                            state_next = ST_STOP;
                            step_next  = SP_CMD;
                        end
                    end
                    default: step_next = SP_REG;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_INIT;
            step       <= SP_REG;
            status_q   <= STAT_OK;
            timer      <= '0;
            cur_bus    <= '0;
            cur_valid  <= 1'b0;
            req_rd_q   <= 1'b0;
            req_bus_q  <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            rsp_data_q <= '0;
            recover_q  <= 1'b0;
        end else begin
            state <= state_next;
            step  <= step_next;

            if (timer_clr) begin
                timer <= '0;
            end else if ((step == SP_IRQ || step == SP_POLL) && timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end

            if (state == ST_INIT || bus_invalidate) begin
                cur_valid <= 1'b0;
            end else if (bus_update) begin
                cur_valid <= 1'b1;
                cur_bus   <= req_bus_q;
            end

            if (capture) begin
                req_rd_q   <= req_rd_i;
                req_bus_q  <= req_bus_i;
                req_addr_q <= req_addr_i;
                req_data_q <= req_data_i;
                rsp_data_q <= 8'h00;
            end
            if (load_rdata) rsp_data_q <= cmdr;
            if (set_status) status_q <= status_next;

            if (set_recover) begin
                recover_q <= 1'b1;
            end else if (clr_recover) begin
                recover_q <= 1'b0;
            end
        end
    end

    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = status_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench: plays the I2C core's Wishbone slave and interrupt by hand and
// checks each bus access, response and recovery step of the sequencer.
module tb_i2c_xfer_sequencer;
    import i2c_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst, irq, ack;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o, dat_i;
    logic       req_valid, req_ready, req_rd;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [2:0] rsp_status;

    int vectors    = 0;
    int miscompares = 0;
    int lat;

    always #5 clk = ~clk;

    i2c_xfer_sequencer #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .USE_IRQ(1), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
        .ack_i(ack), .dat_i(dat_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd),
        .req_bus_i(req_bus), .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_status_o(rsp_status)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for one access, check it, optionally stall, then ack with rdat.
    task automatic wb_access(input string tag, input logic w, input logic [1:0] a,
                             input logic [7:0] wdat, input logic [7:0] rdat, input int stall);
        int n = 0;
        while (cyc !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_cyc"}, cyc, 1);
        if (cyc === 1'b1) begin
            check(tag, {stb, we, adr, (w ? dat_o : 8'h00)}, {1'b1, w, a, wdat});
            repeat (stall) @(negedge clk);
            if (stall > 0) check({tag, "_hold"}, {cyc, we, adr, (w ? dat_o : 8'h00)}, {1'b1, w, a, wdat});
            dat_i = rdat;
            ack   = 1'b1;
            @(negedge clk);
            ack   = 1'b0;
            dat_i = 8'h00;
            check({tag, "_drop"}, cyc, 0);
        end
    endtask

    task automatic reg_write(input string tag, input logic [1:0] a, input logic [7:0] d);
        wb_access(tag, 1'b1, a, d, 8'h00, 0);
    endtask

    // CMDR write, interrupt, 'polls' not-done reads, then the final status read.
    task automatic cmd_done(input string tag, input logic [7:0] code, input logic [7:0] st, input int polls);
        wb_access({tag, "_cmd"}, 1'b1, REG_CMDR, code, 8'h00, 0);
        irq = 1'b1;
        for (int i = 0; i < polls; i++) wb_access({tag, "_poll"}, 1'b0, REG_CMDR, 8'h00, 8'h00, 0);
        wb_access({tag, "_stat"}, 1'b0, REG_CMDR, 8'h00, st, 0);
        irq = 1'b0;
    endtask

    task automatic request(input string tag, input logic rd, input logic [3:0] bus,
                           input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_rd = rd; req_bus = bus; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_rd    = ~rd;
        req_bus   = 4'($urandom);
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
        check({tag, "_accepted"}, req_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input logic [2:0] st, input logic [7:0] d,
                            input logic idle_after, output int n);
        logic saw_cyc = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (cyc === 1'b1) saw_cyc = 1'b1;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_no_access"}, saw_cyc, 0);
        check({tag, "_status"}, rsp_status, st);
        check({tag, "_data"}, rsp_data, d);
        @(negedge clk);
        check({tag, "_after"}, {rsp_valid, req_ready}, {1'b0, idle_after});
    endtask

    task automatic init_seq(input string tag);
        wb_access({tag, "_csr"}, 1'b1, REG_CSR, 8'hC0, 8'h00, 2);
        check({tag, "_ready_lo"}, req_ready, 0);
        @(negedge clk);
        check({tag, "_ready_hi"}, req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; irq = 1'b0; ack = 1'b0; dat_i = 8'h00;
        req_valid = 1'b0; req_rd = 1'b0; req_bus = 4'h0; req_addr = 7'h00; req_data = 8'h00;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {cyc, stb, we, adr, dat_o, req_ready, rsp_valid, rsp_data, rsp_status}, 32'h0);
        rst = 1'b0;
        init_seq("init");

        // Write, bus 2 (first use -> SET_BUS), addr 0x22, data 0xA5.
        request("w", 1'b0, 4'd2, 7'h22, 8'hA5);
        reg_write("w_setbus_dpr", REG_DPR, 8'h02);
        cmd_done("w_setbus", 8'h06, 8'h80, 1);
        cmd_done("w_start", 8'h04, 8'h80, 0);
        reg_write("w_addr_dpr", REG_DPR, 8'h44);
        cmd_done("w_addr", 8'h01, 8'h80, 0);
        reg_write("w_data_dpr", REG_DPR, 8'hA5);
        cmd_done("w_data", 8'h01, 8'h80, 2);
        cmd_done("w_stop", 8'h05, 8'h80, 0);
        wait_rsp("w_rsp", 3'd0, 8'h00, 1'b1, lat);

        // Read from the same bus: no SET_BUS, slave byte 0x3C.
        request("r", 1'b1, 4'd2, 7'h22, 8'h00);
        cmd_done("r_start", 8'h04, 8'h80, 0);
        reg_write("r_addr_dpr", REG_DPR, 8'h45);
        cmd_done("r_addr", 8'h01, 8'h80, 0);
        cmd_done("r_data", 8'h03, 8'h80, 0);
        wb_access("r_dpr_read", 1'b0, REG_DPR, 8'h00, 8'h3C, 1);
        cmd_done("r_stop", 8'h05, 8'h80, 0);
        wait_rsp("r_rsp", 3'd0, 8'h3C, 1'b1, lat);

        // Address NAK (0xC0): STOP still issued, no data phase, status NAK.
        request("n", 1'b0, 4'd2, 7'h22, 8'h5A);
        cmd_done("n_start", 8'h04, 8'h80, 0);
        reg_write("n_addr_dpr", REG_DPR, 8'h44);
        cmd_done("n_addr", 8'h01, 8'hC0, 0);
        cmd_done("n_stop", 8'h05, 8'h80, 0);
        wait_rsp("n_rsp", 3'd1, 8'h00, 1'b1, lat);

        // Stray ack with no cycle open must be ignored.
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("stray_ack", {cyc, req_ready, rsp_valid}, 3'b010);

        // All status bits set: ERR wins, no STOP.
        request("e", 1'b0, 4'd2, 7'h22, 8'h01);
        cmd_done("e_start", 8'h04, 8'hF0, 0);
        wait_rsp("e_rsp", 3'd3, 8'h00, 1'b1, lat);

        // DON+AL: ARB_LOST, no STOP, bus forgotten.
        request("a", 1'b0, 4'd2, 7'h22, 8'h02);
        cmd_done("a_start", 8'h04, 8'hA0, 0);
        wait_rsp("a_rsp", 3'd2, 8'h00, 1'b1, lat);

        // Same bus again must re-issue SET_BUS; irq never comes -> TIMEOUT.
        request("t", 1'b0, 4'd2, 7'h22, 8'h03);
        reg_write("t_setbus_dpr", REG_DPR, 8'h02);
        wb_access("t_setbus_cmd", 1'b1, REG_CMDR, 8'h06, 8'h00, 0);
        wait_rsp("t_rsp", 3'd4, 8'h00, 1'b0, lat);
        // Roughly TIMEOUT_CYCLES after the command ack, allowing pipeline slack.
        check("t_latency", (lat >= 63 && lat <= 67), 1);
        reg_write("t_csr_off", REG_CSR, 8'h00);
        init_seq("t_reinit");

        // After recovery SET_BUS is re-issued; then reset lands during WDATA.
        request("x", 1'b0, 4'd2, 7'h22, 8'hA5);
        reg_write("x_setbus_dpr", REG_DPR, 8'h02);
        cmd_done("x_setbus", 8'h06, 8'h80, 0);
        cmd_done("x_start", 8'h04, 8'h80, 0);
        reg_write("x_addr_dpr", REG_DPR, 8'h44);
        cmd_done("x_addr", 8'h01, 8'h80, 0);
        lat = 0;
        while (cyc !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        check("x_wdata_access", {cyc, we, adr, dat_o}, {1'b1, 1'b1, REG_DPR, 8'hA5});
        #2 rst = 1'b1;
        #1 check("x_async_drop", {cyc, stb, we, adr, dat_o, req_ready, rsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("x_no_rsp", rsp_valid, 0);
        init_seq("x_reinit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
